// File: rtl/sy_ppl_wb_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : sy_ppl_wb_arb_if
// Brief    : Requester-side and register-file-side bundle of the writeback
//            arbiter (slave = arbiter, master = execution units + RF port).
// Revision : 1.0  initial release
// ============================================================================
interface sy_ppl_wb_arb_if #(
  parameter int NUM_REQ     = 5,
  parameter int DATA_WTH    = 64,
  parameter int PHY_REG_WTH = 7,
  parameter int ROB_WTH     = 6
);
  localparam int c_src_wth = $clog2(NUM_REQ);

  logic                            flush_i;
  logic [NUM_REQ-1:0]              req_vld_i;
  logic [NUM_REQ-1:0]              req_rdy_o;
  logic [NUM_REQ*DATA_WTH-1:0]     req_data_i;
  logic [NUM_REQ*PHY_REG_WTH-1:0]  req_idx_i;
  logic [NUM_REQ-1:0]              req_is_fp_i;
  logic [NUM_REQ*ROB_WTH-1:0]      req_rob_i;
  logic                            wb_vld_o;
  logic                            wb_rdy_i;
  logic [DATA_WTH-1:0]             wb_data_o;
  logic [PHY_REG_WTH-1:0]          wb_idx_o;
  logic                            wb_is_fp_o;
  logic [ROB_WTH-1:0]              wb_rob_o;
  logic [c_src_wth-1:0]            wb_src_o;
  logic [31:0]                     conflict_cnt_o;

  modport slave (
    input  flush_i, req_vld_i, req_data_i, req_idx_i, req_is_fp_i, req_rob_i,
           wb_rdy_i,
    output req_rdy_o, wb_vld_o, wb_data_o, wb_idx_o, wb_is_fp_o, wb_rob_o,
           wb_src_o, conflict_cnt_o
  );

  modport master (
    output flush_i, req_vld_i, req_data_i, req_idx_i, req_is_fp_i, req_rob_i,
           wb_rdy_i,
    input  req_rdy_o, wb_vld_o, wb_data_o, wb_idx_o, wb_is_fp_o, wb_rob_o,
           wb_src_o, conflict_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/sy_ppl_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : sy_ppl_wb_arb
// Brief    : Round-robin arbiter for the shared physical-register writeback
//            port, registered output with valid/ready backpressure and flush.
//            Optional macro SY_WB_ARB_PERF_EN builds the conflict counter.
// Revision : 1.0  initial release
// ============================================================================
module sy_ppl_wb_arb #(
  parameter int NUM_REQ     = 5,
  parameter int DATA_WTH    = 64,
  parameter int PHY_REG_WTH = 7,
  parameter int ROB_WTH     = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sy_ppl_wb_arb_if.slave   bus
);
  localparam int                   c_src_wth = $clog2(NUM_REQ);
  localparam logic [c_src_wth-1:0] c_last    = c_src_wth'(NUM_REQ - 1);

  logic                    r_wb_vld;
  logic [DATA_WTH-1:0]     r_wb_data;
  logic [PHY_REG_WTH-1:0]  r_wb_idx;
  logic                    r_wb_is_fp;
  logic [ROB_WTH-1:0]      r_wb_rob;
  logic [c_src_wth-1:0]    r_wb_src;
  logic [c_src_wth-1:0]    r_rr_ptr;

  logic                    w_load;
  logic                    w_found;
  logic [c_src_wth-1:0]    w_cand;
  logic [c_src_wth-1:0]    w_gnt_idx;
  logic [NUM_REQ-1:0]      w_gnt_oh;
  logic [c_src_wth-1:0]    w_rr_nxt;
  logic [DATA_WTH-1:0]     w_data;
  logic [PHY_REG_WTH-1:0]  w_idx;
  logic                    w_is_fp;
  logic [ROB_WTH-1:0]      w_rob;

  function automatic logic [c_src_wth-1:0] f_wrap(input int v);
    return (v >= NUM_REQ) ? c_src_wth'(v - NUM_REQ) : c_src_wth'(v);
  endfunction

  assign w_load = (!r_wb_vld || bus.wb_rdy_i) && !bus.flush_i;

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    w_found   = 1'b0;
    w_cand    = '0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = f_wrap(i + int'(r_rr_ptr));
      if (!w_found && bus.req_vld_i[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    w_gnt_oh[w_gnt_idx] = w_found;
  end

  always_comb begin
    w_data  = '0;
    w_idx   = '0;
    w_is_fp = 1'b0;
    w_rob   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_data  = bus.req_data_i[i*DATA_WTH +: DATA_WTH];
        w_idx   = bus.req_idx_i[i*PHY_REG_WTH +: PHY_REG_WTH];
        w_is_fp = bus.req_is_fp_i[i];
        w_rob   = bus.req_rob_i[i*ROB_WTH +: ROB_WTH];
      end
    end
  end

  assign w_rr_nxt      = (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
  assign bus.req_rdy_o = w_load ? w_gnt_oh : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb_vld   <= 1'b0;
      r_wb_data  <= '0;
      r_wb_idx   <= '0;
      r_wb_is_fp <= 1'b0;
      r_wb_rob   <= '0;
      r_wb_src   <= '0;
      r_rr_ptr   <= '0;
    end else if (bus.flush_i) begin
      r_wb_vld <= 1'b0;
    end else if (w_load) begin
      r_wb_vld <= w_found;
      if (w_found) begin
        r_wb_data  <= w_data;
        r_wb_idx   <= w_idx;
        r_wb_is_fp <= w_is_fp;
        r_wb_rob   <= w_rob;
        r_wb_src   <= w_gnt_idx;
        r_rr_ptr   <= w_rr_nxt;
      end
    end
  end

  assign bus.wb_vld_o   = r_wb_vld;
  assign bus.wb_data_o  = r_wb_data;
  assign bus.wb_idx_o   = r_wb_idx;
  assign bus.wb_is_fp_o = r_wb_is_fp;
  assign bus.wb_rob_o   = r_wb_rob;
  assign bus.wb_src_o   = r_wb_src;

`ifdef SY_WB_ARB_PERF_EN
  logic [31:0] r_conflict_cnt;
  logic        w_multi;

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign w_multi = (bus.req_vld_i & (bus.req_vld_i - 1'b1)) != '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_conflict_cnt <= '0;
    end else if (w_load && w_multi && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign bus.conflict_cnt_o = r_conflict_cnt;
`else
  assign bus.conflict_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sy_ppl_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sy_ppl_wb_arb
// Brief    : Directed self-checking bench for the writeback arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_sy_ppl_wb_arb;
  localparam int NUM_REQ     = 5;
  localparam int DATA_WTH    = 64;
  localparam int PHY_REG_WTH = 7;
  localparam int ROB_WTH     = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sy_ppl_wb_arb_if #(
    .NUM_REQ(NUM_REQ), .DATA_WTH(DATA_WTH),
    .PHY_REG_WTH(PHY_REG_WTH), .ROB_WTH(ROB_WTH)
  ) bus ();

  sy_ppl_wb_arb #(
    .NUM_REQ(NUM_REQ), .DATA_WTH(DATA_WTH),
    .PHY_REG_WTH(PHY_REG_WTH), .ROB_WTH(ROB_WTH)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Fixed per-requester payloads
  function automatic logic [63:0] f_data(input int i);
    return 64'h0123_4567_89AB_0000 + 64'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input int src);
    check({tag, " vld"},  64'(bus.wb_vld_o),   64'd1);
    check({tag, " src"},  64'(bus.wb_src_o),   64'(src));
    check({tag, " data"}, bus.wb_data_o,       f_data(src));
    check({tag, " idx"},  64'(bus.wb_idx_o),   64'(10 + src));
    check({tag, " fp"},   64'(bus.wb_is_fp_o), 64'(src % 2));
    check({tag, " rob"},  64'(bus.wb_rob_o),   64'(20 + src));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush_i   = 1'b0;
    bus.req_vld_i = '0;
    bus.wb_rdy_i  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_data_i[i*DATA_WTH +: DATA_WTH]       = f_data(i);
      bus.req_idx_i[i*PHY_REG_WTH +: PHY_REG_WTH]  = PHY_REG_WTH'(10 + i);
      bus.req_is_fp_i[i]                           = (i % 2) == 1;
      bus.req_rob_i[i*ROB_WTH +: ROB_WTH]          = ROB_WTH'(20 + i);
    end

    // Reset state
    tick(); tick();
    check("rst vld",  64'(bus.wb_vld_o),       64'd0);
    check("rst src",  64'(bus.wb_src_o),       64'd0);
    check("rst data", bus.wb_data_o,           64'd0);
    check("rst rdy",  64'(bus.req_rdy_o),      64'd0);
    check("rst cnt",  64'(bus.conflict_cnt_o), 64'd0);
    rst = 1'b0;
    tick();

    // Single requester, same-cycle rdy, next-cycle output
    bus.req_vld_i = 5'b00001;
    bus.wb_rdy_i  = 1'b1;
    #1 check("t1 rdy", 64'(bus.req_rdy_o), 64'b00001);
    tick();
    check_wb("t1", 0);
    bus.req_vld_i = '0;
    #1 check("t1 idle rdy", 64'(bus.req_rdy_o), 64'd0);
    tick();
    check("t1 idle vld", 64'(bus.wb_vld_o), 64'd0);

    // Full rotation from a fresh pointer, no bubbles
    rst = 1'b1; #1 rst = 1'b0;
    bus.req_vld_i = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("t2 rdy%0d", k), 64'(bus.req_rdy_o), 64'(1 << (k % 5)));
      tick();
      check($sformatf("t2 vld%0d", k), 64'(bus.wb_vld_o), 64'd1);
      check($sformatf("t2 src%0d", k), 64'(bus.wb_src_o), 64'(k % 5));
    end
    // rr_ptr now 1, wb shows req0

    // Backpressure holds the output
    bus.wb_rdy_i  = 1'b0;
    bus.req_vld_i = 5'b00100;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("t3 rdy%0d", k), 64'(bus.req_rdy_o), 64'd0);
      tick();
      check_wb($sformatf("t3 hold%0d", k), 0);
    end
    bus.wb_rdy_i = 1'b1;
    #1 check("t3 rdy", 64'(bus.req_rdy_o), 64'b00100);
    tick();
    check_wb("t3 out", 2);

    // Move rr_ptr to 4, then wrap past req4 to req1
    bus.req_vld_i = 5'b01000;
    tick();
    check_wb("t4 pre", 3);
    bus.req_vld_i = 5'b10010;
    #1 check("t4 rdy4", 64'(bus.req_rdy_o), 64'b10000);
    tick();
    check_wb("t4 g4", 4);
    bus.req_vld_i = 5'b00010;
    #1 check("t4 rdy1", 64'(bus.req_rdy_o), 64'b00010);
    tick();
    check_wb("t4 g1", 1);
    // rr_ptr now 2

    // Flush drops output, grants nothing, keeps rr_ptr
    bus.req_vld_i = 5'b01000;
    bus.flush_i   = 1'b1;
    #1 check("t5 rdy", 64'(bus.req_rdy_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    check("t5 vld", 64'(bus.wb_vld_o), 64'd0);
    bus.req_vld_i = 5'b00101;
    #1 check("t5 ptr", 64'(bus.req_rdy_o), 64'b00100);
    tick();
    check_wb("t5 out", 2);

    // Conflict counter over 10 contended edges
    rst = 1'b1; #1 rst = 1'b0;
    bus.req_vld_i = 5'b00111;
    for (int k = 0; k < 10; k++) tick();
`ifdef SY_WB_ARB_PERF_EN
    check("t6 cnt", 64'(bus.conflict_cnt_o), 64'd10);
`else
    check("t6 cnt", 64'(bus.conflict_cnt_o), 64'd0);
`endif
    check("t6 vld", 64'(bus.wb_vld_o), 64'd1);

    // Async reset mid-transfer clears without a clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t7 vld", 64'(bus.wb_vld_o),       64'd0);
    check("t7 cnt", 64'(bus.conflict_cnt_o), 64'd0);
    check("t7 src", 64'(bus.wb_src_o),       64'd0);
    rst = 1'b0;
    bus.req_vld_i = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
